uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
Parametrised successor to the basic UART transmitter. It buffers outgoing words in a small FIFO and serialises them LSB-first. The frame format is configurable: start bit, DATA_BITS data bits, optional odd/even parity, then 1 or 2 stop bits. It sits between a system-clock producer (valid/ready write side) and the TX pin, and sends frames back-to-back with no idle gap while data is queued.

Parameters:
DATA_BITS, 8, data bits per frame (5..9)
BAUD, 9600, line bit rate
SYS_CLK, 12000000, clk frequency in Hz
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame (1 or 2)
FIFO_DEPTH, 4, queue entries (power of 2, >= 2)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tx_valid  input  1  producer has a word
tx_data  input  DATA_BITS  word to send
tx_ready  output  1  FIFO not full; write accepted when tx_valid && tx_ready at rising clk
tx_wire  output  1  serial line, idle high, registered
busy  output  1  high while a frame is on the line
fifo_count  output  $clog2(FIFO_DEPTH+1)  words queued, excluding the word in flight

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values: tx_wire=1, busy=0, tx_ready=1, fifo_count=0, FSM=IDLE, FIFO pointers=0. Reset has priority over every other event.
- Bit timing: CLKS_PER_BIT = SYS_CLK/BAUD, truncating integer division (1250 at the defaults). The baud counter runs 0..CLKS_PER_BIT-1 and restarts on every state entry. Each bit holds exactly CLKS_PER_BIT clocks.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if the FIFO is non-empty, pop the head into the shift register and go to START. tx_wire=0 from the next edge; busy=1.
  - START -> DATA after 1 bit period.
  - DATA: output shift[0], shift right each bit period; DATA_BITS periods, then PARITY (if PARITY!=0) or STOP.
  - PARITY: 1 bit period. Even: XOR of the data bits. Odd: the inverse.
  - STOP: tx_wire=1 for STOP_BITS bit periods. At the end, if the FIFO is non-empty, pop and enter START directly (no idle cycle); otherwise go to IDLE with busy=0.
- Latency: a write accepted at edge N into an empty FIFO while IDLE gives the pop at edge N+1. tx_wire falls at edge N+1.
- FIFO:
  - tx_ready = (fifo_count != FIFO_DEPTH), combinational from registered state.
  - Write and pop in the same cycle: fifo_count unchanged, both take effect.
  - A write while full is ignored; the producer must hold tx_valid/tx_data.
  - Pointers wrap modulo FIFO_DEPTH.
  - Pop from an empty FIFO never occurs.
- tx_data is captured at write. Later changes do not affect queued words.
- Reset mid-frame: at the edge with rst=1, tx_wire returns to 1 immediately and the FIFO is flushed. The partial frame is abandoned; queued words are discarded.
- tx_wire is driven from a flop only, so it is glitch-free.

Test Plan:
1. Idle: rst for 2 cycles, then no writes for 10 bit periods (12500 clks) -> tx_wire held 1, busy=0, tx_ready=1, fifo_count=0.
2. Single frame (PARITY=0, STOP_BITS=1): write 0x5A -> tx_wire falls at the next edge. Sample at 625+k*1250 clks after the fall: 0,0,1,0,1,1,0,1,0,1. busy falls 12500 clks after the fall.
3. Parity: PARITY=2 with 0x07 -> bit 9 = 1. PARITY=1 with 0x07 -> bit 9 = 0. Frame is 11 bits, stop high at bit 10.
4. Full/back-to-back (FIFO_DEPTH=4):
   - Drive tx_valid continuously with 0x01..0x06 (advance only on accept).
   - The 0x01 write is popped one cycle later; 0x02..0x05 fill the FIFO; tx_ready=0 at fifo_count=4.
   - 0x06 is accepted on the cycle after the next pop.
   - Six frames go out in order, each start bit immediately following the previous stop bit; busy stays 1 throughout.
5. Reset mid-frame: queue 0x11, 0x22, 0x33; assert rst for 1 cycle during data bit 3 of 0x11 -> tx_wire=1 from that edge, fifo_count=0, busy=0, no further low bits for 5 bit periods.
6. STOP_BITS=2: write 0xFF, 0x00 back-to-back -> line high for exactly 2500 clks between the last data bit of 0xFF and the start bit of 0x00.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// FIFO-buffered UART transmitter: start bit, DATA_BITS data bits LSB-first,
// optional parity and 1 or 2 stop bits, with frames sent back-to-back while words are queued.
module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int BAUD       = 9600,
  parameter int SYS_CLK    = 12000000,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            tx_valid,
  input  logic [DATA_BITS-1:0]            tx_data,
  output logic                            tx_ready,
  output logic                            tx_wire,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int CLKS_PER_BIT = SYS_CLK / BAUD;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W  = $clog2(DATA_BITS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [DATA_BITS-1:0] shift;
  logic                 parity_bit;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic                 bit_done;
  logic                 last_stop;
  logic                 push;
  logic                 pop;

  assign tx_ready  = (fifo_count != CNT_W'(FIFO_DEPTH));
  assign push      = tx_valid && tx_ready;
  assign bit_done  = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign last_stop = (state == S_STOP) && bit_done && (bit_cnt == BIT_W'(STOP_BITS - 1));
  // A pop starts a new frame either from idle or straight out of the final stop bit.
  assign pop       = (fifo_count != '0) && ((state == S_IDLE) || last_stop);

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      tx_wire    <= 1'b1;
      busy       <= 1'b0;
      shift      <= '0;
      parity_bit <= 1'b0;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
    end else if (pop) begin
      state      <= S_START;
      tx_wire    <= 1'b0;
      busy       <= 1'b1;
      shift      <= mem[rd_ptr];
      parity_bit <= (^mem[rd_ptr]) ^ (PARITY == 1);
      baud_cnt   <= '0;
      bit_cnt    <= '0;
    end else begin
      baud_cnt <= bit_done ? '0 : baud_cnt + BAUD_W'(1);
      case (state)
        S_IDLE: begin
          tx_wire  <= 1'b1;
          busy     <= 1'b0;
          baud_cnt <= '0;
        end
        S_START: begin
          if (bit_done) begin
            state   <= S_DATA;
            tx_wire <= shift[0];
            bit_cnt <= '0;
          end
        end
        S_DATA: begin
          if (bit_done) begin
            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
              bit_cnt <= '0;
              if (PARITY != 0) begin
                state   <= S_PARITY;
                tx_wire <= parity_bit;
              end else begin
                state   <= S_STOP;
                tx_wire <= 1'b1;
              end
            end else begin
              shift   <= shift >> 1;
              tx_wire <= shift[1];
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        S_PARITY: begin
          if (bit_done) begin
            state   <= S_STOP;
            tx_wire <= 1'b1;
            bit_cnt <= '0;
          end
        end
        S_STOP: begin
          if (bit_done) begin
            if (last_stop) begin
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
